sobel_stream: RTL and testbench

- Parametrised streaming 3x3 Sobel edge filter, next generation of the 8-bit fixed-size filter.
- Sits between two FWFT FIFOs in the image pipeline.
- Produces one output pixel per input pixel, so the output frame size equals the input frame size:
  - border pixels are forced to 0;
  - an end-of-frame flush emits the last row.
- Adds configurable pixel width, an optional binary threshold mode, and back-to-back frame support.

---
 rtl/sobel_stream_if.sv | 19 +
 rtl/sobel_stream.sv | 104 ++++++++++
 tb/tb_sobel_stream.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/sobel_stream_if.sv
// sobel_stream_if: FWFT input-FIFO read side and output-FIFO write side of the Sobel filter
interface sobel_stream_if #(
  parameter int DWIDTH = 8
);
  logic              in_rd_en;
  logic [DWIDTH-1:0] in_dout;
  logic              in_empty;
  logic              out_wr_en;
  logic [DWIDTH-1:0] out_din;
  logic              out_full;
  modport master (
    output in_rd_en, out_wr_en, out_din,
    input  in_dout, in_empty, out_full
  );
  modport slave (
    input  in_rd_en, out_wr_en, out_din,
    output in_dout, in_empty, out_full
  );
endinterface

// File: rtl/sobel_stream.sv
// sobel_stream: streaming 3x3 Sobel edge filter, one output pixel per input pixel
module sobel_stream #(
  parameter int DWIDTH     = 8,
  parameter int IMG_WIDTH  = 720,
  parameter int IMG_HEIGHT = 540,
  parameter int THRESH     = 0
) (
  input  logic          clock,
  input  logic          reset,
  sobel_stream_if.master io
);
  localparam int DEPTH = 2*IMG_WIDTH+3;
  localparam int NPIX  = IMG_WIDTH*IMG_HEIGHT;
  localparam int NW    = $clog2(NPIX);
  localparam int XW    = $clog2(IMG_WIDTH+1);
  localparam int YW    = $clog2(IMG_HEIGHT);
  localparam int SW    = DWIDTH+4;
  localparam logic [SW-1:0] TH = SW'(THRESH);
  typedef enum logic [1:0] {FILL, STREAM, FLUSH} state_t;
  state_t state_q, state_d;
  logic [DWIDTH-1:0] win_q [DEPTH];
  logic [DWIDTH-1:0] win_d [DEPTH];
  logic [NW-1:0] n_q, n_d;
  logic [XW-1:0] cx_q, cx_d, fc_q, fc_d;
  logic [YW-1:0] cy_q, cy_d;
  logic out_valid_q, out_valid_d;
  logic [DWIDTH-1:0] out_din_q, out_din_d;
  logic ready, accept, step, produce, done, last_px, last_fl, cx_wrap, border;
  logic signed [SW-1:0] gx, gy;
  logic [SW-1:0] ax, ay, mag;
  logic [DWIDTH-1:0] sat, res;
  function automatic logic signed [SW-1:0] tap(input int r, input int c);
    return $signed({4'b0, win_d[(2-r)*IMG_WIDTH+2-c]});
  endfunction
  always_ff @(posedge clock) begin
    if (!reset) state_q <= FILL;
    else state_q <= state_d;
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      FILL:    if (accept && n_q == NW'(IMG_WIDTH)) state_d = STREAM;
      STREAM:  if (accept && last_px) state_d = FLUSH;
      FLUSH:   if (done) state_d = FILL;
      default: state_d = FILL;
    endcase
  end
  always_comb begin
    ready = ~out_valid_q | ~io.out_full;
    accept = reset & ~io.in_empty & (state_q != FLUSH) & ((state_q == FILL) | ready);
    step = reset & (state_q == FLUSH) & ready;
    produce = (accept & (state_q == STREAM)) | step;
    io.in_rd_en = accept;
    io.out_wr_en = reset & out_valid_q & ~io.out_full;
  end
  assign io.out_din = out_din_q;
  // Flush steps push zeros so the last row's centres reach window[IMG_WIDTH+1].
  always_comb begin
    win_d[0] = (accept | step) ? (step ? '0 : io.in_dout) : win_q[0];
    for (int i = 1; i < DEPTH; i++) win_d[i] = (accept | step) ? win_q[i-1] : win_q[i];
  end
  // Taps come from the post-shift window so the result lands with the pop.
  always_comb begin
    gx = (tap(0,2) + (tap(1,2) <<< 1) + tap(2,2)) - (tap(0,0) + (tap(1,0) <<< 1) + tap(2,0));
    gy = (tap(2,0) + (tap(2,1) <<< 1) + tap(2,2)) - (tap(0,0) + (tap(0,1) <<< 1) + tap(0,2));
    ax = gx[SW-1] ? SW'(-gx) : SW'(gx);
    ay = gy[SW-1] ? SW'(-gy) : SW'(gy);
    mag = ax + ay;
    sat = |mag[SW-1:DWIDTH] ? '1 : mag[DWIDTH-1:0];
    cx_wrap = cx_q == XW'(IMG_WIDTH-1);
    border = (cx_q == '0) | cx_wrap | (cy_q == '0) | (cy_q == YW'(IMG_HEIGHT-1));
    res = border ? '0 : (THRESH == 0) ? sat : ({4'b0, sat} >= TH ? '1 : '0);
  end
  always_comb begin
    last_px = n_q == NW'(NPIX-1);
    last_fl = fc_q == XW'(IMG_WIDTH);
    done = step & last_fl;
    n_d = done ? '0 : accept ? n_q + NW'(1) : n_q;
    fc_d = done ? '0 : step ? fc_q + XW'(1) : fc_q;
    cx_d = done ? '0 : produce ? (cx_wrap ? '0 : cx_q + XW'(1)) : cx_q;
    cy_d = done ? '0 : (produce & cx_wrap) ? cy_q + YW'(1) : cy_q;
    out_valid_d = produce | (out_valid_q & io.out_full);
    out_din_d = produce ? res : out_din_q;
  end
  always_ff @(posedge clock) begin
    if (!reset) begin
      win_q <= '{default: '0};
      n_q <= '0;
      fc_q <= '0;
      cx_q <= '0;
      cy_q <= '0;
      out_valid_q <= 1'b0;
      out_din_q <= '0;
    end else begin
      win_q <= win_d;
      n_q <= n_d;
      fc_q <= fc_d;
      cx_q <= cx_d;
      cy_q <= cy_d;
      out_valid_q <= out_valid_d;
      out_din_q <= out_din_d;
    end
  end
endmodule

// File: tb/tb_sobel_stream.sv
// tb_sobel_stream: three filters (THRESH 0/150/250) fed in lockstep, checked against a 2D Sobel model
module tb_sobel_stream;
  localparam int W = 8, H = 6, N = W*H;
  logic clock = 1'b0, reset = 1'b0;
  always #5 clock = ~clock;
  sobel_stream_if #(.DWIDTH(8)) if0(), if1(), if2();
  sobel_stream #(.DWIDTH(8), .IMG_WIDTH(W), .IMG_HEIGHT(H), .THRESH(0))   dut0 (.clock(clock), .reset(reset), .io(if0));
  sobel_stream #(.DWIDTH(8), .IMG_WIDTH(W), .IMG_HEIGHT(H), .THRESH(150)) dut1 (.clock(clock), .reset(reset), .io(if1));
  sobel_stream #(.DWIDTH(8), .IMG_WIDTH(W), .IMG_HEIGHT(H), .THRESH(250)) dut2 (.clock(clock), .reset(reset), .io(if2));
  int checks = 0, errors = 0;
  int got0[$], got1[$], got2[$], feed[$];
  int img_a[N], img_b[N];
  int push_full, rd_skew;

  function automatic int ref_px(input int img[N], input int th, input int i);
    int y = i / W, x = i % W, gx, gy, m;
    if (x == 0 || x == W-1 || y == 0 || y == H-1) return 0;
    gx = img[(y-1)*W+x+1] + 2*img[y*W+x+1] + img[(y+1)*W+x+1]
       - img[(y-1)*W+x-1] - 2*img[y*W+x-1] - img[(y+1)*W+x-1];
    gy = img[(y+1)*W+x-1] + 2*img[(y+1)*W+x] + img[(y+1)*W+x+1]
       - img[(y-1)*W+x-1] - 2*img[(y-1)*W+x] - img[(y-1)*W+x+1];
    m = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
    if (m > 255) m = 255;
    if (th != 0) m = (m >= th) ? 255 : 0;
    return m;
  endfunction

  task automatic drive(input bit e, input logic [7:0] d, input bit f);
    if0.in_empty = e; if1.in_empty = e; if2.in_empty = e;
    if0.in_dout = d;  if1.in_dout = d;  if2.in_dout = d;
    if0.out_full = f; if1.out_full = f; if2.out_full = f;
  endtask

  task automatic sample(input bit f);
    if (if0.out_wr_en) got0.push_back(int'(if0.out_din));
    if (if1.out_wr_en) got1.push_back(int'(if1.out_din));
    if (if2.out_wr_en) got2.push_back(int'(if2.out_din));
    if (f && (if0.out_wr_en || if1.out_wr_en || if2.out_wr_en)) push_full++;
    if (if1.in_rd_en !== if0.in_rd_en || if2.in_rd_en !== if0.in_rd_en) rd_skew++;
    if (if0.in_rd_en && feed.size() > 0) void'(feed.pop_front());
  endtask

  task automatic run(input int pe, input int pf, input int nexp);
    int cyc = 0;
    bit e, f;
    while (got0.size() < nexp && cyc < 2000) begin
      @(negedge clock);
      cyc++;
      e = feed.size() == 0 || $urandom_range(0, 99) < pe;
      f = $urandom_range(0, 99) < pf;
      drive(e, feed.size() > 0 ? 8'(feed[0]) : 8'd0, f);
      #1;
      sample(f);
    end
    checks++;
    if (got0.size() < nexp) begin
      errors++;
      $display("FAIL timeout: got %0d outputs, need %0d", got0.size(), nexp);
    end
    repeat (12) begin
      @(negedge clock);
      drive(1'b1, 8'd0, 1'b0);
      #1;
      sample(1'b0);
    end
  endtask

  task automatic load(input int img[N]);
    for (int i = 0; i < N; i++) feed.push_back(img[i]);
  endtask

  task automatic clear();
    got0.delete(); got1.delete(); got2.delete(); feed.delete();
    push_full = 0; rd_skew = 0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    drive(1'b0, 8'd9, 1'b0);
    repeat (2) @(negedge clock);
    #1;
    checks++;
    if (if0.in_rd_en !== 1'b0 || if0.out_wr_en !== 1'b0) begin
      errors++;
      $display("FAIL reset_handshake: rd_en=%b wr_en=%b, need 0 0", if0.in_rd_en, if0.out_wr_en);
    end
    checks++;
    if (if0.out_din !== 8'd0 || if1.out_din !== 8'd0 || if2.out_din !== 8'd0) begin
      errors++;
      $display("FAIL reset_out_din: %0d %0d %0d, need 0", if0.out_din, if1.out_din, if2.out_din);
    end
    drive(1'b1, 8'd0, 1'b0);
    @(negedge clock);
    reset = 1'b1;
    drive(1'b0, 8'd9, 1'b1);
    #1;
    checks++;
    if (if0.in_rd_en !== 1'b1 || if0.out_wr_en !== 1'b0) begin
      errors++;
      $display("FAIL fill_after_reset: rd_en=%b wr_en=%b, need 1 0", if0.in_rd_en, if0.out_wr_en);
    end
    drive(1'b1, 8'd0, 1'b0);
  endtask

  task automatic test_flat();
    clear();
    for (int i = 0; i < N; i++) img_a[i] = 77;
    load(img_a);
    run(0, 0, N);
    checks++;
    if (got0.size() != N) begin
      errors++;
      $display("FAIL flat_count: got %0d, need %0d", got0.size(), N);
    end
    for (int i = 0; i < got0.size() && i < N; i++) begin
      checks++;
      if (got0[i] !== 0) begin
        errors++;
        $display("FAIL flat_px[%0d]: got %0d, need 0", i, got0[i]);
      end
    end
    @(negedge clock);
    drive(1'b0, 8'd1, 1'b1);
    #1;
    checks++;
    if (if0.in_rd_en !== 1'b1) begin
      errors++;
      $display("FAIL back_to_fill: rd_en=%b with out_full=1, need 1", if0.in_rd_en);
    end
    drive(1'b1, 8'd0, 1'b0);
  endtask

  task automatic test_step();
    clear();
    for (int i = 0; i < N; i++) img_a[i] = (i % W) >= 4 ? 50 : 0;
    load(img_a);
    run(0, 0, N);
    checks++;
    if (got0.size() != N || got1.size() != N || got2.size() != N) begin
      errors++;
      $display("FAIL step_count: got %0d/%0d/%0d, need %0d", got0.size(), got1.size(), got2.size(), N);
    end
    for (int i = 0; i < N && i < got0.size() && i < got1.size() && i < got2.size(); i++) begin
      checks++;
      if (got0[i] !== ref_px(img_a, 0, i) || got1[i] !== ref_px(img_a, 150, i) || got2[i] !== ref_px(img_a, 250, i)) begin
        errors++;
        $display("FAIL step_px[%0d]: got %0d/%0d/%0d, need %0d/%0d/%0d", i, got0[i], got1[i], got2[i],
                 ref_px(img_a, 0, i), ref_px(img_a, 150, i), ref_px(img_a, 250, i));
      end
    end
  endtask

  task automatic test_saturate();
    clear();
    for (int i = 0; i < N; i++) img_a[i] = (i % W) >= 4 ? 100 : 0;
    load(img_a);
    run(0, 0, N);
    checks++;
    if (got0.size() != N) begin
      errors++;
      $display("FAIL sat_count: got %0d, need %0d", got0.size(), N);
    end
    for (int i = 0; i < N && i < got0.size(); i++) begin
      checks++;
      if (got0[i] !== ref_px(img_a, 0, i)) begin
        errors++;
        $display("FAIL sat_px[%0d]: got %0d, need %0d", i, got0[i], ref_px(img_a, 0, i));
      end
    end
  endtask

  task automatic test_random();
    clear();
    for (int i = 0; i < N; i++) img_a[i] = int'($urandom_range(0, 255));
    load(img_a);
    run(30, 30, N);
    checks++;
    if (got0.size() != N || push_full != 0 || rd_skew != 0) begin
      errors++;
      $display("FAIL rand_flow: count %0d (need %0d), pushes while full %0d, pop skew %0d (need 0)",
               got0.size(), N, push_full, rd_skew);
    end
    for (int i = 0; i < N && i < got0.size() && i < got1.size(); i++) begin
      checks++;
      if (got0[i] !== ref_px(img_a, 0, i) || got1[i] !== ref_px(img_a, 150, i)) begin
        errors++;
        $display("FAIL rand_px[%0d]: got %0d/%0d, need %0d/%0d", i, got0[i], got1[i],
                 ref_px(img_a, 0, i), ref_px(img_a, 150, i));
      end
    end
  endtask

  task automatic test_back_to_back();
    clear();
    for (int i = 0; i < N; i++) begin
      img_a[i] = int'($urandom_range(0, 255));
      img_b[i] = int'($urandom_range(0, 255));
    end
    load(img_a);
    load(img_b);
    run(0, 0, 2*N);
    checks++;
    if (got0.size() != 2*N) begin
      errors++;
      $display("FAIL b2b_count: got %0d, need %0d", got0.size(), 2*N);
    end
    for (int i = 0; i < 2*N && i < got0.size(); i++) begin
      checks++;
      if (got0[i] !== (i < N ? ref_px(img_a, 0, i) : ref_px(img_b, 0, i - N))) begin
        errors++;
        $display("FAIL b2b_px[%0d]: got %0d, need %0d", i, got0[i],
                 i < N ? ref_px(img_a, 0, i) : ref_px(img_b, 0, i - N));
      end
    end
  endtask

  task automatic test_mid_reset();
    int cyc = 0;
    clear();
    for (int i = 0; i < 20; i++) feed.push_back(int'($urandom_range(0, 255)));
    while (feed.size() > 0 && cyc < 200) begin
      @(negedge clock);
      cyc++;
      drive(1'b0, 8'(feed[0]), 1'b0);
      #1;
      sample(1'b0);
    end
    @(negedge clock);
    drive(1'b1, 8'd0, 1'b0);
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    clear();
    for (int i = 0; i < N; i++) img_a[i] = (i % W) >= 4 ? 50 : 0;
    load(img_a);
    run(0, 0, N);
    checks++;
    if (got0.size() != N) begin
      errors++;
      $display("FAIL mid_reset_count: got %0d, need %0d", got0.size(), N);
    end
    for (int i = 0; i < N && i < got0.size(); i++) begin
      checks++;
      if (got0[i] !== ref_px(img_a, 0, i)) begin
        errors++;
        $display("FAIL mid_reset_px[%0d]: got %0d, need %0d", i, got0[i], ref_px(img_a, 0, i));
      end
    end
  endtask

  initial begin
    drive(1'b1, 8'd0, 1'b0);
    test_reset();
    test_flat();
    test_step();
    test_saturate();
    test_random();
    test_back_to_back();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
